ear_threshold_ctrl: RTL
=======================

Name: ear_threshold_ctrl

Overview:
Adaptive threshold controller for the EAR (tape/line-in) Schmitt comparator. It tracks the peak magnitude of the incoming audio samples over fixed-length windows. From each window peak it computes a noise threshold and drives that threshold into the comparator's threshold input in place of a fixed constant. It also reports whether a real signal is present, for the loader/status logic. It sits between the audio ADC sample stream and the EAR comparator.

Parameters:
AUDIO_DW, 16, sample width (two's complement).
WINDOW_LOG2, 12, log2 of the number of accepted samples per measurement window.
THRESH_SHIFT, 2, threshold candidate = window peak >> THRESH_SHIFT.
THRESH_MIN, 16'h00FF, lower clamp on the threshold; also the reset value.
THRESH_MAX, 16'h1000, upper clamp on the threshold.
SILENCE_LEVEL, 16'h0400, a window peak at or below this value counts as a silent window.
SILENT_WINDOWS, 2, number of consecutive silent windows that clears signal_present.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  tracking enable
din  in  AUDIO_DW  audio sample, two's complement
din_valid  in  1  sample strobe, one cycle per sample
threshold  out  AUDIO_DW  current threshold, fed to the comparator
threshold_valid  out  1  one-cycle pulse on each threshold update
signal_present  out  1  a signal above the silence level is present

Behaviour:
- Clocking and reset: single clock clk. reset is asynchronous, active-high. On reset: threshold=THRESH_MIN, threshold_valid=0, signal_present=0, state=IDLE, peak=0, sample count=0, silent-window count=0.
- Sample acceptance: a sample is accepted only when din_valid=1 and enable=1. Gaps between samples are allowed.
- Magnitude: if din MSB=1, mag=~din (ones' complement, matching the comparator's convention); otherwise mag=din. mag MSB is therefore always 0.
- States:
  - IDLE: entered from any state when enable=0, and on reset. peak and count cleared; threshold held.
  - ACQUIRE: entered from IDLE when enable=1. Moves to TRACK after the first window closes.
  - TRACK: stays until enable=0.
- Accumulation: on each accepted sample, peak<=max(peak,mag) and count<=count+1 (WINDOW_LOG2 bits, wraps).
- Window close: the accepted sample with count==2^WINDOW_LOG2-1 closes the window, and that sample is included in the peak.
  - wpeak = max(peak, mag).
  - cand = wpeak>>THRESH_SHIFT, clamped to [THRESH_MIN, THRESH_MAX].
  - On the next clock edge: peak<=0, count wraps to 0, threshold_valid=1 for exactly one cycle.
  - ACQUIRE: threshold<=cand.
  - TRACK: threshold<=(threshold+cand)>>1. The sum is computed at AUDIO_DW+1 bits, so there is no overflow. The result lies between the two operands and therefore stays inside the clamp range.
- Latency: threshold changes on the edge that accepts the window's last sample, i.e. it is visible one cycle after that sample is presented.
- signal_present, updated at each window close:
  - wpeak>SILENCE_LEVEL: set to 1 and clear the silent counter.
  - Otherwise: increment the silent counter (saturating). signal_present<=0 when the incremented value reaches SILENT_WINDOWS.
- enable falling mid-window, including on the same cycle as the would-be last sample: that sample is not accepted, the partial window is discarded and no update occurs. On re-enable, the state is ACQUIRE.
- signal_present is held while in IDLE.
- reset mid-window: all state is lost immediately (asynchronous); threshold returns to THRESH_MIN.
- threshold_valid is never asserted in two consecutive cycles: a window needs at least 2^WINDOW_LOG2 accepted samples.

Test Plan:
Bench parameters: WINDOW_LOG2=2, defaults otherwise.
1. Reset and first window: assert reset, then enable=1 and samples 0x1000, 0xF000, 0x2000, 0x0100 -> threshold=0x0800 one cycle after the 4th sample; threshold_valid pulses once; signal_present=1.
2. Smoothing: next window 0x4000, 0x0000, 0xC000, 0x0010 -> cand=0x1000 and threshold=(0x0800+0x1000)>>1=0x0C00. Note ~0xC000=0x3FFF, which is below 0x4000.
3. Clamps:
   - Window peak 0x7FFF from ACQUIRE -> threshold=0x1000 (THRESH_MAX).
   - Window peak 0x0200 from ACQUIRE -> threshold=0x00FF (THRESH_MIN).
4. Silence: after scenario 1, two windows of all 0x0010 -> signal_present stays 1 after the first silent window and drops to 0 at the second window close. Threshold converges toward 0x00FF: 0x0800→0x047F→0x02BF.
5. Abort and gaps:
   - 3 samples, then enable=0 together with a 4th din_valid -> no threshold_valid; threshold unchanged. Re-enable and send 4 samples -> ACQUIRE direct load.
   - din_valid with 5-cycle gaps -> identical results to back-to-back samples.
6. Async reset mid-window: pulse reset between clock edges after 2 samples -> threshold=0x00FF and signal_present=0 immediately; the next full window behaves as ACQUIRE.

Source files
------------

// File: rtl/ear_threshold_ctrl.sv
// Adaptive threshold controller for the EAR Schmitt comparator.
// Tracks windowed peak magnitude and derives a smoothed, clamped threshold plus a signal-present flag.
module ear_threshold_ctrl #(
   parameter int unsigned         AUDIO_DW       = 16,
   parameter int unsigned         WINDOW_LOG2    = 12,
   parameter int unsigned         THRESH_SHIFT   = 2,
   parameter logic [AUDIO_DW-1:0] THRESH_MIN     = 16'h00FF,
   parameter logic [AUDIO_DW-1:0] THRESH_MAX     = 16'h1000,
   parameter logic [AUDIO_DW-1:0] SILENCE_LEVEL  = 16'h0400,
   parameter int unsigned         SILENT_WINDOWS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [AUDIO_DW-1:0] din,
   input  logic                din_valid,
   output logic [AUDIO_DW-1:0] threshold,
   output logic                threshold_valid,
   output logic                signal_present
);

   localparam int unsigned SIL_W = (SILENT_WINDOWS < 2) ? 1 : $clog2(SILENT_WINDOWS + 1);
   localparam logic [SIL_W-1:0] SIL_LIMIT = SIL_W'(SILENT_WINDOWS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [AUDIO_DW-1:0]    peak_q, peak_d;
   logic [WINDOW_LOG2-1:0] count_q, count_d;
   logic [SIL_W-1:0]       sil_q, sil_d, sil_inc;
   logic [AUDIO_DW-1:0]    thr_d;
   logic                   tv_d, sp_d;

   logic [AUDIO_DW-1:0]    mag, wpeak, shifted, cand, avg;
   logic [AUDIO_DW:0]      sum;
   logic                   accept, win_close;

   // Datapath: ones'-complement magnitude, window peak, clamped candidate and running average
   always_comb begin
      mag       = din[AUDIO_DW-1] ? ~din : din;
      wpeak     = (mag > peak_q) ? mag : peak_q;
      accept    = din_valid & enable;
      win_close = accept && (count_q == '1);
      shifted   = wpeak >> THRESH_SHIFT;
      if (shifted < THRESH_MIN)
         cand = THRESH_MIN;
      else if (shifted > THRESH_MAX)
         cand = THRESH_MAX;
      else
         cand = shifted;
      sum     = {1'b0, threshold} + {1'b0, cand};
      avg     = sum[AUDIO_DW:1];
      sil_inc = (sil_q == SIL_LIMIT) ? sil_q : sil_q + SIL_W'(1);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      peak_d  = peak_q;
      count_d = count_q;
      sil_d   = sil_q;
      thr_d   = threshold;
      tv_d    = 1'b0;
      sp_d    = signal_present;

      if (!enable) begin
         // Dropping enable discards any partial window
         state_d = IDLE;
         peak_d  = '0;
         count_d = '0;
      end else begin
         if (state_q == IDLE)
            state_d = ACQUIRE;
         if (accept) begin
            peak_d  = wpeak;
            count_d = count_q + WINDOW_LOG2'(1);
            if (win_close) begin
               peak_d  = '0;
               tv_d    = 1'b1;
               thr_d   = (state_q == TRACK) ? avg : cand;
               state_d = TRACK;
               if (wpeak > SILENCE_LEVEL) begin
                  sp_d  = 1'b1;
                  sil_d = '0;
               end else begin
                  sil_d = sil_inc;
                  if (sil_inc >= SIL_LIMIT)
                     sp_d = 1'b0;
               end
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         peak_q          <= '0;
         count_q         <= '0;
         sil_q           <= '0;
         threshold       <= THRESH_MIN;
         threshold_valid <= 1'b0;
         signal_present  <= 1'b0;
      end else begin
         state_q         <= state_d;
         peak_q          <= peak_d;
         count_q         <= count_d;
         sil_q           <= sil_d;
         threshold       <= thr_d;
         threshold_valid <= tv_d;
         signal_present  <= sp_d;
      end
   end

endmodule
